vital_alarm_detect: RTL and testbench
=====================================

# vital_alarm_detect

- Upstream front end of the post-op alarm path; produces the `alarm` and `history` levels consumed by the alarm-escalation FSM.
- Qualifies sampled vitals (heart rate, optionally SpO2) against fixed limits and debounces over consecutive samples.
- Flags an alarm episode as a repeat (`history`) when it starts soon after the previous episode ended.

## Interface
Parameters:
- HR_MIN, 50: lowest in-range heart rate (bpm, inclusive).
- HR_MAX, 120: highest in-range heart rate (bpm, inclusive).
- SPO2_MIN, 90: lowest in-range SpO2 (%, inclusive).
- PERSIST, 3: consecutive violating samples needed to raise an alarm. The same count of consecutive in-range samples clears it. Legal range is 1..15.
- HIST_WIN, 16: valid samples after an episode ends during which a new episode counts as a repeat. Legal range is 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- sw  in  1  post-op monitoring enable (same switch as the downstream FSM).
- clear0  in  1  operator clear of history; level, sampled every cycle.
- sample_valid  in  1  one-cycle strobe: hr/spo2 valid this cycle.
- hr  in  8  heart rate, unsigned bpm.
- spo2  in  7  SpO2, unsigned percent.
- alarm  out  1  alarm episode active.
- history  out  1  current or recent episode is a repeat.
- alarm_code  out  2  violation flags of the last accepted sample. Bit0 is HR, bit1 is SpO2.

## Operation
- Violation per sample, evaluated only when sample_valid=1:
  - v_hr = (hr < HR_MIN) | (hr > HR_MAX).
  - v_sp = (spo2 < SPO2_MIN).
  - viol = v_hr | v_sp.
- All comparisons are unsigned at the port width. Limits themselves are in range.
- State register takes values IDLE, MONITOR, PENDING, ALARMED, RECOVER. It uses a 4-bit run counter `cnt`.
- Global rule: sw=0 in any state forces IDLE next cycle. This clears cnt, history, the window timer and alarm_code. It has priority over every other event.
- IDLE: sw=1 goes to MONITOR. Samples are ignored while in IDLE.
- MONITOR:
  - valid & viol: cnt=1. Go to ALARMED if PERSIST=1, else PENDING.
  - valid & !viol: stay.
- PENDING:
  - valid & viol: cnt+1. Go to ALARMED when the incremented value equals PERSIST.
  - valid & !viol: cnt=0, go to MONITOR.
- ALARMED:
  - valid & !viol: cnt=1. Go to MONITOR if PERSIST=1, else RECOVER.
  - valid & viol: cnt=0, stay.
- RECOVER:
  - valid & !viol: cnt+1. Go to MONITOR when it reaches PERSIST.
  - valid & viol: cnt=0, go to ALARMED.
- alarm = 1 iff state is ALARMED or RECOVER (Moore decode of the state register).
- Window timer `win` (8 bit) and flag `recent`:
  - Any transition into MONITOR from RECOVER or ALARMED loads win=0 and sets recent=1.
  - In MONITOR/PENDING, each valid sample does win+1. When win+1 = HIST_WIN, clear recent.
- history:
  - Set on a transition into ALARMED from MONITOR or PENDING if recent=1 in that cycle.
  - Cleared by clear0=1, or by sw=0.
  - Also cleared in the cycle recent expires while the state is not ALARMED/RECOVER.
  - clear0 also clears recent.
  - clear0 and a set event in the same cycle: clear wins.
- alarm_code is loaded {v_sp, v_hr} on every valid sample outside IDLE.

## Timing
- Reset values: state=IDLE, alarm=0, history=0, alarm_code=2'b00, cnt=0, win=0, recent=0.
- All outputs are registered or decoded from registers. There is no combinational path from input to output.
- Latency:
  - alarm rises the cycle after the sample_valid cycle carrying the PERSIST-th consecutive violation.
  - alarm falls the cycle after the PERSIST-th consecutive in-range sample.
  - history rises in the same cycle as alarm for a repeat episode.
- sample_valid is accepted back-to-back, every cycle. Non-valid cycles never change cnt or win.
- Counters saturate safely: cnt never exceeds PERSIST, and win stops counting once recent=0.
- rst mid-episode: everything returns to reset values on the next edge regardless of sw.

## Configuration
- VITAL_SPO2_EN defined: SpO2 channel active as specified.
- VITAL_SPO2_EN undefined:
  - v_sp is forced 0 and the spo2 port is ignored.
  - alarm_code[1] is constant 0.
  - SPO2_MIN is unused.

## Test plan
- sw=1, hr=130 on 3 consecutive valid samples -> alarm=1 one cycle after the 3rd; history=0; alarm_code=2'b01.
- hr=130, 130, 80, 130, 130 -> alarm stays 0 (run broken at the 3rd sample); state is PENDING with cnt=2 after the 5th.
- Raise alarm, recover with 3× hr=80, then 5 valid in-range samples, then 3× hr=40 -> alarm=1 and history=1 together.
- Same sequence but 16 in-range samples between episodes -> second alarm=1, history=0.
- history=1 with alarm=1, assert clear0 for 1 cycle -> history=0 next cycle; alarm stays 1.
- Episode active with history=1, sw=0 -> next cycle alarm=0, history=0, alarm_code=0.
- VITAL_SPO2_EN defined, spo2=85 ×3 -> alarm=1, alarm_code=2'b10. Undefined: no alarm.

Source files
------------

// File: rtl/vital_alarm_detect.sv
// vital_alarm_detect: qualifies sampled vitals against fixed limits, debounces
// violations into alarm episodes and flags episodes that start soon after the
// previous one ended (history).
// Optional SpO2 channel: define VITAL_SPO2_EN to enable it.
module vital_alarm_detect #(
    parameter int unsigned HR_MIN   = 50,
    parameter int unsigned HR_MAX   = 120,
    parameter int unsigned SPO2_MIN = 90,
    parameter int unsigned PERSIST  = 3,
    parameter int unsigned HIST_WIN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw,
    input  logic       clear0,
    input  logic       sample_valid,
    input  logic [7:0] hr,
    input  logic [6:0] spo2,
    output logic       alarm,
    output logic       history,
    output logic [1:0] alarm_code
);

    localparam int unsigned HR_W  = 8;
    localparam int unsigned SP_W  = 7;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned WIN_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MONITOR = 3'd1,
        PENDING = 3'd2,
        ALARMED = 3'd3,
        RECOVER = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [WIN_W-1:0]   win, win_nxt;
    logic               recent, recent_nxt;
    logic               history_nxt;
    logic               alarm_nxt;
    logic [1:0]         code_nxt;

    logic               v_hr;
    logic               v_sp;
    logic               viol;
    logic [CNT_W-1:0]   cnt_inc;
    logic [WIN_W-1:0]   win_inc;

    assign v_hr = (hr < HR_W'(HR_MIN)) || (hr > HR_W'(HR_MAX));
`ifdef VITAL_SPO2_EN
    assign v_sp = (spo2 < SP_W'(SPO2_MIN));
`else
    // SpO2 channel disabled: port and limit intentionally unused
    logic unused_spo2;
    assign unused_spo2 = &{1'b0, spo2, SP_W'(SPO2_MIN)};
    assign v_sp = 1'b0;
`endif
    assign viol    = v_hr | v_sp;
    assign cnt_inc = cnt + CNT_W'(1);
    assign win_inc = win + WIN_W'(1);

    // Next-state, run counter, repeat window and output register logic
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        win_nxt     = win;
        recent_nxt  = recent;
        history_nxt = history;
        code_nxt    = alarm_code;

        if (!sw) begin
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            win_nxt     = '0;
            recent_nxt  = 1'b0;
            history_nxt = 1'b0;
            code_nxt    = 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = MONITOR;
                end
                MONITOR: begin
                    if (sample_valid && viol) begin
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = (PERSIST == 1) ? ALARMED : PENDING;
                    end
                end
                PENDING: begin
                    if (sample_valid) begin
                        if (viol) begin
                            cnt_nxt = cnt_inc;
                            if (cnt_inc == CNT_W'(PERSIST)) begin
                                state_nxt = ALARMED;
                            end
                        end else begin
                            cnt_nxt   = '0;
                            state_nxt = MONITOR;
                        end
                    end
                end
                ALARMED: begin
                    if (sample_valid) begin
                        if (!viol) begin
                            cnt_nxt   = CNT_W'(1);
                            state_nxt = (PERSIST == 1) ? MONITOR : RECOVER;
                        end else begin
                            cnt_nxt = '0;
                        end
                    end
                end
                RECOVER: begin
                    if (sample_valid) begin
                        if (!viol) begin
                            cnt_nxt = cnt_inc;
                            if (cnt_inc == CNT_W'(PERSIST)) begin
                                state_nxt = MONITOR;
                            end
                        end else begin
                            cnt_nxt   = '0;
                            state_nxt = ALARMED;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase

            // Episode end opens the repeat window; samples outside an episode age it
            if ((state_nxt == MONITOR) && ((state == ALARMED) || (state == RECOVER))) begin
                win_nxt    = '0;
                recent_nxt = 1'b1;
            end else if (sample_valid && recent && ((state == MONITOR) || (state == PENDING))) begin
                win_nxt = win_inc;
                if (win_inc == WIN_W'(HIST_WIN)) begin
                    recent_nxt = 1'b0;
                end
            end

            // A new episode inside the window is a repeat; an expiring window
            // outside an episode retires the flag
            if ((state_nxt == ALARMED) && ((state == MONITOR) || (state == PENDING))) begin
                if (recent) begin
                    history_nxt = 1'b1;
                end
            end else if (recent && !recent_nxt &&
                         (state != ALARMED) && (state != RECOVER)) begin
                history_nxt = 1'b0;
            end

            if (clear0) begin
                history_nxt = 1'b0;
                recent_nxt  = 1'b0;
            end

            if (sample_valid && (state != IDLE)) begin
                code_nxt = {v_sp, v_hr};
            end
        end

        alarm_nxt = (state_nxt == ALARMED) || (state_nxt == RECOVER);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            win        <= '0;
            recent     <= 1'b0;
            history    <= 1'b0;
            alarm      <= 1'b0;
            alarm_code <= 2'b00;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            win        <= win_nxt;
            recent     <= recent_nxt;
            history    <= history_nxt;
            alarm      <= alarm_nxt;
            alarm_code <= code_nxt;
        end
    end

endmodule

// File: tb/tb_vital_alarm_detect.sv
// Testbench for vital_alarm_detect: directed scenarios plus randomized
// traffic checked against an episode-level reference model.
module tb_vital_alarm_detect;

    localparam int P_HR_MIN   = 50;
    localparam int P_HR_MAX   = 120;
    localparam int P_SPO2_MIN = 90;
    localparam int P_PERSIST  = 3;
    localparam int P_HIST_WIN = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       sw;
    logic       clear0;
    logic       sample_valid;
    logic [7:0] hr;
    logic [6:0] spo2;
    logic       alarm;
    logic       history;
    logic [1:0] alarm_code;

    int checks   = 0;
    int failures = 0;

    // Reference model state: episode flag, run length, samples since last
    // episode end (-1 = no open window), history, last code, enabled flag
    bit       m_on;
    bit       m_alarm;
    int       m_run;
    int       m_since;
    bit       m_hist;
    bit [1:0] m_code;

    vital_alarm_detect #(
        .HR_MIN  (P_HR_MIN),
        .HR_MAX  (P_HR_MAX),
        .SPO2_MIN(P_SPO2_MIN),
        .PERSIST (P_PERSIST),
        .HIST_WIN(P_HIST_WIN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sw          (sw),
        .clear0      (clear0),
        .sample_valid(sample_valid),
        .hr          (hr),
        .spo2        (spo2),
        .alarm       (alarm),
        .history     (history),
        .alarm_code  (alarm_code)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit vh;
        bit vs;
        bit viol;
        bit was_recent;
        bit expire;
        if (rst) begin
            m_on = 0; m_alarm = 0; m_run = 0; m_since = -1; m_hist = 0; m_code = 2'b00;
        end else if (!sw) begin
            m_on = 0; m_alarm = 0; m_run = 0; m_since = -1; m_hist = 0; m_code = 2'b00;
        end else begin
            if (!m_on) begin
                m_on = 1;
            end else if (sample_valid) begin
                vh = (int'(hr) < P_HR_MIN) || (int'(hr) > P_HR_MAX);
`ifdef VITAL_SPO2_EN
                vs = int'(spo2) < P_SPO2_MIN;
`else
                vs = 0;
`endif
                viol   = vh || vs;
                m_code = {vs, vh};
                if (!m_alarm) begin
                    was_recent = (m_since >= 0);
                    expire     = 0;
                    if (m_since >= 0) begin
                        m_since++;
                        if (m_since == P_HIST_WIN) begin
                            m_since = -1;
                            expire  = 1;
                        end
                    end
                    m_run = viol ? m_run + 1 : 0;
                    if (m_run == P_PERSIST) begin
                        m_alarm = 1;
                        m_run   = 0;
                        if (was_recent) m_hist = 1;
                    end else if (expire) begin
                        m_hist = 0;
                    end
                end else begin
                    m_run = viol ? 0 : m_run + 1;
                    if (m_run == P_PERSIST) begin
                        m_alarm = 0;
                        m_run   = 0;
                        m_since = 0;
                    end
                end
            end
            if (clear0) begin
                m_hist  = 0;
                m_since = -1;
            end
        end
    endtask

    // One clock: apply inputs, advance the model at the edge, settle past the edge
    task automatic cyc(input bit r, input bit s, input bit c0, input bit v,
                       input logic [7:0] h, input logic [6:0] sp);
        rst = r; sw = s; clear0 = c0; sample_valid = v; hr = h; spo2 = sp;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic samp(input logic [7:0] h);
        cyc(0, 1, 0, 1, h, 7'd97);
    endtask

    task automatic start();
        cyc(1, 1, 0, 0, 8'd80, 7'd97);
        cyc(0, 1, 0, 0, 8'd80, 7'd97);
    endtask

    // Raise an episode, recover, wait gap in-range samples, raise again
    task automatic two_episodes(input int gap);
        start();
        repeat (3) samp(8'd130);
        repeat (3) samp(8'd80);
        repeat (gap) samp(8'd80);
        repeat (3) samp(8'd40);
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0, 8'd0, 7'd0);
        cyc(1, 1, 0, 1, 8'd200, 7'd10);
        checks++;
        if ({alarm, history, alarm_code} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_state: got alarm=%0b history=%0b code=%b want 0 0 00", alarm, history, alarm_code);
        end
    endtask

    task automatic test_persist_raise();
        start();
        samp(8'd130);
        cyc(0, 1, 0, 0, 8'd80, 7'd97);
        samp(8'd130);
        checks++;
        if (alarm !== 1'b0) begin
            failures++;
            $display("FAIL raise_early: alarm=%0b want 0", alarm);
        end
        samp(8'd130);
        checks++;
        if ({alarm, history, alarm_code} !== 4'b1001) begin
            failures++;
            $display("FAIL raise_third: got alarm=%0b history=%0b code=%b want 1 0 01", alarm, history, alarm_code);
        end
        repeat (2) samp(8'd80);
        checks++;
        if ({alarm, alarm_code} !== 3'b100) begin
            failures++;
            $display("FAIL recover_mid: got alarm=%0b code=%b want 1 00", alarm, alarm_code);
        end
        samp(8'd80);
        checks++;
        if (alarm !== 1'b0) begin
            failures++;
            $display("FAIL recover_fall: alarm=%0b want 0", alarm);
        end
    endtask

    task automatic test_broken_run();
        logic [7:0] seq [5];
        seq[0] = 8'd130; seq[1] = 8'd130; seq[2] = 8'd80; seq[3] = 8'd130; seq[4] = 8'd130;
        start();
        for (int i = 0; i < 5; i++) begin
            samp(seq[i]);
            checks++;
            if (alarm !== 1'b0) begin
                failures++;
                $display("FAIL broken_run[%0d]: alarm=%0b want 0", i, alarm);
            end
        end
        samp(8'd130);
        checks++;
        if (alarm !== 1'b1) begin
            failures++;
            $display("FAIL broken_run_resume: alarm=%0b want 1", alarm);
        end
    endtask

    task automatic test_history_repeat();
        two_episodes(5);
        checks++;
        if ({alarm, history, alarm_code} !== 4'b1101) begin
            failures++;
            $display("FAIL repeat_gap5: got alarm=%0b history=%0b code=%b want 1 1 01", alarm, history, alarm_code);
        end
        two_episodes(12);
        checks++;
        if ({alarm, history} !== 2'b11) begin
            failures++;
            $display("FAIL repeat_gap12: got alarm=%0b history=%0b want 1 1", alarm, history);
        end
    endtask

    task automatic test_window_expiry();
        two_episodes(16);
        checks++;
        if ({alarm, history} !== 2'b10) begin
            failures++;
            $display("FAIL expiry_gap16: got alarm=%0b history=%0b want 1 0", alarm, history);
        end
    endtask

    task automatic test_clear0();
        two_episodes(5);
        cyc(0, 1, 1, 0, 8'd40, 7'd97);
        checks++;
        if ({alarm, history} !== 2'b10) begin
            failures++;
            $display("FAIL clear0: got alarm=%0b history=%0b want 1 0", alarm, history);
        end
        cyc(0, 1, 0, 0, 8'd40, 7'd97);
        checks++;
        if ({alarm, history} !== 2'b10) begin
            failures++;
            $display("FAIL clear0_hold: got alarm=%0b history=%0b want 1 0", alarm, history);
        end
    endtask

    task automatic test_sw_off();
        two_episodes(5);
        cyc(0, 0, 0, 1, 8'd40, 7'd97);
        checks++;
        if ({alarm, history, alarm_code} !== 4'b0000) begin
            failures++;
            $display("FAIL sw_off: got alarm=%0b history=%0b code=%b want 0 0 00", alarm, history, alarm_code);
        end
    endtask

    task automatic test_spo2();
        start();
        repeat (3) cyc(0, 1, 0, 1, 8'd80, 7'd85);
        checks++;
`ifdef VITAL_SPO2_EN
        if ({alarm, alarm_code} !== 3'b110) begin
            failures++;
            $display("FAIL spo2_on: got alarm=%0b code=%b want 1 10", alarm, alarm_code);
        end
`else
        if ({alarm, alarm_code} !== 3'b000) begin
            failures++;
            $display("FAIL spo2_off: got alarm=%0b code=%b want 0 00", alarm, alarm_code);
        end
`endif
    endtask

    task automatic test_rst_mid();
        two_episodes(5);
        cyc(1, 1, 0, 1, 8'd40, 7'd97);
        checks++;
        if ({alarm, history, alarm_code} !== 4'b0000) begin
            failures++;
            $display("FAIL rst_mid: got alarm=%0b history=%0b code=%b want 0 0 00", alarm, history, alarm_code);
        end
    endtask

    task automatic test_back_to_back();
        bit         bad_mode;
        bit         r;
        bit         s;
        bit         c0;
        bit         v;
        logic [7:0] h;
        logic [6:0] sp;
        bad_mode = 0;
        cyc(1, 1, 0, 0, 8'd80, 7'd97);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) bad_mode = ~bad_mode;
            r  = ($urandom_range(0, 599) == 0);
            s  = ($urandom_range(0, 79) != 0);
            c0 = ($urandom_range(0, 59) == 0);
            v  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: h = bad_mode ? 8'($urandom_range(0, 49))   : 8'($urandom_range(50, 120));
                1: h = bad_mode ? 8'($urandom_range(121, 255)) : 8'($urandom_range(50, 120));
                2: h = bad_mode ? 8'(49 + 72 * $urandom_range(0, 1)) : 8'(50 + 70 * $urandom_range(0, 1));
                default: h = 8'($urandom_range(0, 255));
            endcase
            sp = bad_mode ? 7'($urandom_range(70, 95)) : 7'($urandom_range(90, 100));
            cyc(r, s, c0, v, h, sp);
            checks++;
            if ({alarm, history, alarm_code} !== {m_alarm, m_hist, m_code}) begin
                failures++;
                $display("FAIL random[%0d]: got alarm=%0b history=%0b code=%b want %0b %0b %b",
                         i, alarm, history, alarm_code, m_alarm, m_hist, m_code);
            end
        end
    endtask

    initial begin
        rst = 1'b1; sw = 1'b0; clear0 = 1'b0; sample_valid = 1'b0; hr = 8'd80; spo2 = 7'd97;
        m_on = 0; m_alarm = 0; m_run = 0; m_since = -1; m_hist = 0; m_code = 2'b00;
        test_reset();
        test_persist_raise();
        test_broken_run();
        test_history_repeat();
        test_window_expiry();
        test_clear0();
        test_sw_off();
        test_spo2();
        test_rst_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
